// File: rtl/spi_s_rx.sv
// SPI slave receiver: synchronises SCLK/MOSI/CS_N into i_clk, deserialises
// MSB-first into bytes, strobes each completed byte and flags truncated frames.
module spi_s_rx #(
  parameter logic CPOL = 1'b0,
  parameter logic CPHA = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_spi_clk,
  input  logic       i_spi_rx,
  input  logic       i_spi_cs_n,
  output logic [7:0] o_rx_data,
  output logic       o_rx_data_valid,
  output logic       o_rx_frame_err,
  output logic       o_rx_busy
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic       sclk_s1, sclk_s2, sclk_s3;
  logic       mosi_s1, mosi_s2;
  logic       cs_s1, cs_s2, cs_s3;
  logic [2:0] sync_fill;
  logic [0:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;

  logic sync_ok;
  logic lead_edge;
  logic trail_edge;
  logic sample;
  logic cs_fall;
  logic cs_rise;

  // After reset the s2/s3 pair only reflects the pins once three samples have
  // been taken; until then edges are suppressed so reset never fakes a CS_N fall.
  assign sync_ok    = sync_fill[2];
  assign lead_edge  = sync_ok && (sclk_s2 != CPOL) && (sclk_s3 == CPOL);
  assign trail_edge = sync_ok && (sclk_s2 == CPOL) && (sclk_s3 != CPOL);
  assign sample     = CPHA ? trail_edge : lead_edge;
  assign cs_fall    = sync_ok && !cs_s2 &&  cs_s3;
  assign cs_rise    = sync_ok &&  cs_s2 && !cs_s3;
  assign o_rx_busy  = ~cs_s2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the synchroniser chain relies on that ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: every flop, including the shift register, is reset here so the
      // receiver restarts cleanly even when reset lands mid-frame.
      sclk_s1         <= CPOL;
      sclk_s2         <= CPOL;
      sclk_s3         <= CPOL;
      mosi_s1         <= 1'b0;
      mosi_s2         <= 1'b0;
      cs_s1           <= 1'b1;
      cs_s2           <= 1'b1;
      cs_s3           <= 1'b1;
      sync_fill       <= 3'b000;
      state           <= ST_IDLE;
      bit_cnt         <= 3'd0;
      shift           <= 8'h00;
      o_rx_data       <= 8'h00;
      o_rx_data_valid <= 1'b0;
      o_rx_frame_err  <= 1'b0;
    end else begin
      sclk_s1         <= i_spi_clk;
      sclk_s2         <= sclk_s1;
      sclk_s3         <= sclk_s2;
      mosi_s1         <= i_spi_rx;
      mosi_s2         <= mosi_s1;
      cs_s1           <= i_spi_cs_n;
      cs_s2           <= cs_s1;
      cs_s3           <= cs_s2;
      sync_fill       <= {sync_fill[1:0], 1'b1};
      o_rx_data_valid <= 1'b0;
      o_rx_frame_err  <= 1'b0;

      case (state)
        ST_IDLE: begin
          bit_cnt <= 3'd0;
          if (cs_fall) begin
            state <= ST_ACTIVE;
            shift <= 8'h00;
          end
        end

        ST_ACTIVE: begin
          if (sample) begin
            shift   <= {shift[6:0], mosi_s2};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              o_rx_data       <= {shift[6:0], mosi_s2};
              o_rx_data_valid <= 1'b1;
            end
          end
          // A coincident sample is accounted for first: the error looks at
          // the count as it would stand after that sample.
          if (cs_rise) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
            if (sample) begin
              o_rx_frame_err <= (bit_cnt != 3'd7);
            end else begin
              o_rx_frame_err <= (bit_cnt != 3'd0);
            end
          end
        end

        default: begin
          state   <= ST_IDLE;
          bit_cnt <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_s_rx.sv
// Self-checking bench for spi_s_rx: one instance per SPI mode, a bit-level
// master driving shared pins, and a byte-level model of the expected strobes.
module tb_spi_s_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_clk = 1'b0;
  logic spi_rx = 1'b0;
  logic spi_cs_n = 1'b1;

  logic [7:0] rx_data  [4];
  logic       rx_valid [4];
  logic       rx_err   [4];
  logic       rx_busy  [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam logic [1:0] MODE = 2'(g);
    spi_s_rx #(.CPOL(MODE[1]), .CPHA(MODE[0])) u_dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_spi_clk      (spi_clk),
      .i_spi_rx       (spi_rx),
      .i_spi_cs_n     (spi_cs_n),
      .o_rx_data      (rx_data[g]),
      .o_rx_data_valid(rx_valid[g]),
      .o_rx_frame_err (rx_err[g]),
      .o_rx_busy      (rx_busy[g])
    );
  end

  typedef struct {
    logic [7:0] d;
    int         stamp;
  } rec_t;

  typedef struct {
    int          mode;
    logic [31:0] data;
    int          nbits;
    int          h;
    logic [7:0]  exp_last;
    int          exp_err;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mon_mode = 0;
  int   errcnt = 0;
  int   exp_err = 0;
  rec_t rxq[$];
  rec_t expq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observed strobes of the instance under test, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (rx_valid[mon_mode]) rxq.push_back('{d: rx_data[mon_mode], stamp: cyc});
    if (rx_err[mon_mode]) errcnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    rxq.delete();
    expq.delete();
    errcnt  = 0;
    exp_err = 0;
  endtask

  // Master: data is MSB-first from bit 31; a byte is expected 3 cycles after
  // the pin transition carrying its 8th sample. simul raises CS_N together
  // with the last sample edge; rst_after pulses reset after that bit index.
  task automatic send_frame(input int mode, input logic [31:0] data, input int nbits,
                            input int h, input bit simul, input int rst_after);
    logic cpol, cpha;
    bit   ignored, cs_done;
    cpol    = mode[1];
    cpha    = mode[0];
    ignored = 1'b0;
    cs_done = 1'b0;
    @(negedge clk);
    spi_cs_n = 1'b1;
    spi_clk  = cpol;
    spi_rx   = 1'b0;
    wait_cyc(4);
    spi_cs_n = 1'b0;
    if (!cpha) spi_rx = data[31];
    wait_cyc(h < 3 ? 3 : h);
    check("busy_in_frame", 32'(rx_busy[mode]), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      spi_clk = ~cpol;
      if (cpha) spi_rx = data[31-i];
      else if (i % 8 == 7 && !ignored) expq.push_back('{d: data[31-8*(i/8) -: 8], stamp: cyc + 3});
      if (!cpha && simul && i == nbits - 1) begin
        spi_cs_n = 1'b1;
        cs_done  = 1'b1;
        break;
      end
      wait_cyc(h);
      spi_clk = cpol;
      if (cpha) begin
        if (i % 8 == 7 && !ignored) expq.push_back('{d: data[31-8*(i/8) -: 8], stamp: cyc + 3});
        if (simul && i == nbits - 1) begin
          spi_cs_n = 1'b1;
          cs_done  = 1'b1;
        end
      end else begin
        spi_rx = (i + 1 < nbits) ? data[30-i] : 1'b0;
      end
      wait_cyc(h);
      if (i == rst_after) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_data",  32'(rx_data[mode]),  32'h00);
        check("rst_valid", 32'(rx_valid[mode]), 32'd0);
        check("rst_err",   32'(rx_err[mode]),   32'd0);
        check("rst_busy",  32'(rx_busy[mode]),  32'd0);
        @(negedge clk);
        rst     = 1'b0;
        ignored = 1'b1;
      end
    end
    if (!cs_done) spi_cs_n = 1'b1;
    if (!ignored && (nbits % 8) != 0) exp_err++;
    wait_cyc(6);
    check("busy_after_frame", 32'(rx_busy[mode]), 32'd0);
    spi_clk = cpol;
    wait_cyc(2);
  endtask

  task automatic verify(input string tag);
    check({tag, "_valid_count"}, 32'(rxq.size()), 32'(expq.size()));
    for (int i = 0; i < rxq.size() && i < expq.size(); i++) begin
      check({tag, "_data"},  32'(rxq[i].d),     32'(expq[i].d));
      check({tag, "_stamp"}, 32'(rxq[i].stamp), 32'(expq[i].stamp));
    end
    check({tag, "_err_count"}, 32'(errcnt), 32'(exp_err));
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{mode: 0, data: 32'hA500_0000, nbits: 8,  h: 4, exp_last: 8'hA5, exp_err: 0};
    vecs[1] = '{mode: 1, data: 32'h3C00_0000, nbits: 8,  h: 4, exp_last: 8'h3C, exp_err: 0};
    vecs[2] = '{mode: 2, data: 32'hC300_0000, nbits: 8,  h: 4, exp_last: 8'hC3, exp_err: 0};
    vecs[3] = '{mode: 3, data: 32'h8100_0000, nbits: 8,  h: 4, exp_last: 8'h81, exp_err: 0};
    vecs[4] = '{mode: 0, data: 32'h01FE_5500, nbits: 24, h: 4, exp_last: 8'h55, exp_err: 0};
    vecs[5] = '{mode: 0, data: 32'hFF00_0000, nbits: 5,  h: 4, exp_last: 8'h55, exp_err: 1};
    vecs[6] = '{mode: 0, data: 32'h1200_0000, nbits: 8,  h: 4, exp_last: 8'h12, exp_err: 0};

    rst = 1'b1;
    wait_cyc(3);
    for (int m = 0; m < 4; m++) begin
      check("reset_data",  32'(rx_data[m]),  32'h00);
      check("reset_valid", 32'(rx_valid[m]), 32'd0);
      check("reset_err",   32'(rx_err[m]),   32'd0);
      check("reset_busy",  32'(rx_busy[m]),  32'd0);
    end
    rst = 1'b0;
    wait_cyc(5);

    for (int v = 0; v < 7; v++) begin
      clear_mon();
      mon_mode = vecs[v].mode;
      send_frame(vecs[v].mode, vecs[v].data, vecs[v].nbits, vecs[v].h, 1'b0, -1);
      verify($sformatf("vec%0d", v));
      check($sformatf("vec%0d_last_data", v), 32'(rx_data[vecs[v].mode]), 32'(vecs[v].exp_last));
      check($sformatf("vec%0d_err_table", v), 32'(errcnt), 32'(vecs[v].exp_err));
      if (vecs[v].nbits == 24 && rxq.size() == 3) begin
        check("b2b_spacing01", 32'(rxq[1].stamp - rxq[0].stamp), 32'(16 * vecs[v].h));
        check("b2b_spacing12", 32'(rxq[2].stamp - rxq[1].stamp), 32'(16 * vecs[v].h));
      end
    end

    // Mode-0 master seen by the CPHA=1 instance: one-bit shift expected.
    clear_mon();
    mon_mode = 1;
    send_frame(0, 32'h3C00_0000, 8, 4, 1'b0, -1);
    check("mismatch_count", 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) check("mismatch_data", 32'(rxq[0].d), 32'h78);
    check("mismatch_err", 32'(errcnt), 32'd0);

    // 8th sample edge and CS_N release in the same cycle.
    clear_mon();
    mon_mode = 0;
    send_frame(0, 32'h5A00_0000, 8, 4, 1'b1, -1);
    verify("simul");
    check("simul_data", 32'(rx_data[0]), 32'h5A);

    // Reset after bit 4, then a clean frame.
    clear_mon();
    mon_mode = 0;
    send_frame(0, 32'hF000_0000, 8, 4, 1'b0, 3);
    verify("rst_frame");
    clear_mon();
    send_frame(0, 32'h9B00_0000, 8, 4, 1'b0, -1);
    verify("after_rst");
    check("after_rst_data", 32'(rx_data[0]), 32'h9B);

    for (int r = 0; r < 20; r++) begin
      int mode, nb, extra, h;
      mode  = int'($urandom_range(0, 3));
      nb    = int'($urandom_range(1, 3));
      extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      h     = int'($urandom_range(2, 5));
      clear_mon();
      mon_mode = mode;
      send_frame(mode, $urandom, 8 * nb + extra, h, 1'b0, -1);
      verify($sformatf("rand%0d_m%0d", r, mode));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
